gray_stamp_capture: RTL

Downstream consumer of the 16-bit gray counter.
- On each event pulse (a cochlea channel spike), samples the counter's gray value.
- Converts the sample to binary in a pipeline.
- Buffers timestamps in a small FIFO, which the readout logic drains over a valid/ready interface.
- Counts and flags events lost to a full FIFO.

---
 rtl/gray_stamp_capture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gray_stamp_capture.sv
// gray_stamp_capture: timestamps event pulses against a live 16-bit gray counter.
//
// Each event_in cycle captures gray_in (S1), converts it to binary (S2) and pushes it
// into a small first-word fall-through FIFO (S3) drained over out_valid/out_ready.
// Events that reach S3 with no FIFO room are dropped. A drop sets the sticky overflow
// flag and increments the saturating drop_count. clear_ovf clears both.
//
// Optional feature (macro GRAY_STAMP_DELTA_EN): when defined, the FIFO stores the
// difference from the last accepted timestamp instead of the absolute value.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      asynchronous active-low reset
//   gray_in    live gray counter value (same clock domain)
//   event_in   spike strobe, one event per high cycle
//   out_ready  consumer ready
//   clear_ovf  pulse: clears overflow and drop_count
//   out_valid  FIFO head valid
//   out_time   binary timestamp at FIFO head (holds while out_valid=0)
//   fifo_count occupied entries, 0..DEPTH
//   overflow   sticky drop flag
//   drop_count dropped events, saturating at 255
module gray_stamp_capture #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  gray_in,
  input  logic              event_in,
  input  logic              out_ready,
  input  logic              clear_ovf,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_time,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_gray_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_bin_q;
  logic [WIDTH-1:0] s1_bin;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]  count_q;
  logic [WIDTH-1:0] hold_q;
  logic             overflow_q;
  logic [7:0]       drop_count_q;

  logic             pop;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] push_data;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    s1_bin = '0;
    s1_bin[WIDTH-1] = s1_gray_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      s1_bin[i] = s1_bin[i+1] ^ s1_gray_q[i];
    end
  end

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = s2_valid_q & ((count_q < FullCount) | pop);
  assign drop       = s2_valid_q & ~push;
  assign out_time   = out_valid ? mem_q[rd_ptr_q] : hold_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

`ifdef GRAY_STAMP_DELTA_EN
  logic [WIDTH-1:0] last_b_q;

  // last_b starts at zero, so the first accepted event stores its absolute value.
  assign push_data = s2_bin_q - last_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q <= '0;
    end else if (push) begin
      last_b_q <= s2_bin_q;
    end
  end
`else
  assign push_data = s2_bin_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
    end else begin
      s1_valid_q <= event_in;
      if (event_in) begin
        s1_gray_q <= gray_in;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_bin_q <= s1_bin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      // Remember the head so out_time stays put once the FIFO empties.
      if (out_valid) begin
        hold_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      // A drop in the same cycle as clear_ovf restarts the count at one.
      overflow_q   <= 1'b1;
      drop_count_q <= clear_ovf ? 8'd1 :
                      (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
    end else if (clear_ovf) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

endmodule
